// File: rtl/panda_risc_v_lsu_pkg.sv
// panda_risc_v_lsu_pkg: shared error codes, ls_type encodings and FSM states for the LSU
package panda_risc_v_lsu_pkg;
  localparam logic [1:0] DBUS_ACCESS_NORMAL = 2'b00;
  localparam logic [1:0] DBUS_ACCESS_LS_UNALIGNED = 2'b01;
  localparam logic [1:0] DBUS_ACCESS_BUS_ERR = 2'b10;
  localparam logic [1:0] DBUS_ACCESS_TIMEOUT = 2'b11;
  localparam logic [2:0] LS_TYPE_B = 3'b000;
  localparam logic [2:0] LS_TYPE_H = 3'b001;
  localparam logic [2:0] LS_TYPE_W = 3'b010;
  localparam logic [2:0] LS_TYPE_BU = 3'b100;
  localparam logic [2:0] LS_TYPE_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, CMD, RSP, WBK} lsu_state_t;
  // Any code other than the byte/half forms is treated as a word access
  function automatic logic is_unaligned(input logic [2:0] t, input logic [1:0] a);
    return (t == LS_TYPE_B || t == LS_TYPE_BU) ? 1'b0 :
           (t == LS_TYPE_H || t == LS_TYPE_HU) ? a[0] : |a;
  endfunction
endpackage

// File: rtl/panda_risc_v_lsu_data_fmt.sv
// panda_risc_v_lsu_data_fmt: store lane/mask generation and load extraction/extension
module panda_risc_v_lsu_data_fmt
  import panda_risc_v_lsu_pkg::*;
(
  input  logic        st_sel,
  input  logic [2:0]  st_type,
  input  logic [1:0]  st_ofs,
  input  logic [31:0] din,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  ld_ofs,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);
  logic byte_st, half_st;
  logic [31:0] sh;
  always_comb begin
    byte_st = st_type == LS_TYPE_B || st_type == LS_TYPE_BU;
    half_st = st_type == LS_TYPE_H || st_type == LS_TYPE_HU;
    wdata = byte_st ? {4{din[7:0]}} : half_st ? {2{din[15:0]}} : din;
    wmask = !st_sel ? 4'b0000 : byte_st ? 4'b0001 << st_ofs : half_st ? 4'b0011 << st_ofs : 4'b1111;
    sh = rdata >> {ld_ofs, 3'b000};
    ld_data = ld_type == LS_TYPE_B  ? {{24{sh[7]}}, sh[7:0]} :
              ld_type == LS_TYPE_BU ? {24'd0, sh[7:0]} :
              ld_type == LS_TYPE_H  ? {{16{sh[15]}}, sh[15:0]} :
              ld_type == LS_TYPE_HU ? {16'd0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/panda_risc_v_lsu_core.sv
// panda_risc_v_lsu_core: single-outstanding LSU; bus timeout/stale drain under PANDA_RISC_V_LSU_TIMEOUT_EN
module panda_risc_v_lsu_core
  import panda_risc_v_lsu_pkg::*;
#(
  parameter real simulation_delay = 1,
  parameter int  dbus_timeout_th = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req_ls_sel,
  input  logic [2:0]  s_req_ls_type,
  input  logic [4:0]  s_req_rd_id,
  input  logic [31:0] s_req_ls_addr,
  input  logic [31:0] s_req_ls_din,
  input  logic        s_req_valid,
  output logic        s_req_ready,
  output logic [31:0] m_dbus_cmd_addr,
  output logic        m_dbus_cmd_read,
  output logic [31:0] m_dbus_cmd_wdata,
  output logic [3:0]  m_dbus_cmd_wmask,
  output logic        m_dbus_cmd_valid,
  input  logic        m_dbus_cmd_ready,
  input  logic [31:0] m_dbus_rsp_rdata,
  input  logic        m_dbus_rsp_err,
  input  logic        m_dbus_rsp_valid,
  output logic        m_dbus_rsp_ready,
  output logic        m_lsu_wbk_ls_sel,
  output logic [4:0]  m_lsu_wbk_rd_id_for_ld,
  output logic [31:0] m_lsu_wbk_dout,
  output logic [31:0] m_lsu_wbk_ls_addr,
  output logic [1:0]  m_lsu_wbk_err,
  output logic        m_lsu_wbk_valid,
  input  logic        m_lsu_wbk_ready
);
  if (simulation_delay < 0.0 || dbus_timeout_th < 2) begin : g_param_chk
    $error("panda_risc_v_lsu_core: bad parameters");
  end
  lsu_state_t state, state_nxt;
  logic [2:0] type_q;
  logic [31:0] wdata, ld_data;
  logic [3:0] wmask;
  logic accept, unaligned, cmd_hs, rsp_hs, timeout, stale;
  assign unaligned = is_unaligned(s_req_ls_type, s_req_ls_addr[1:0]);
  assign s_req_ready = state == IDLE && !stale;
  assign accept = s_req_valid && s_req_ready;
  assign cmd_hs = state == CMD && m_dbus_cmd_ready;
  assign rsp_hs = state == RSP && m_dbus_rsp_valid;
  assign m_dbus_cmd_valid = state == CMD;
  assign m_dbus_rsp_ready = state == RSP || stale;
  assign m_lsu_wbk_valid = state == WBK;
  panda_risc_v_lsu_data_fmt u_fmt (
    .st_sel(s_req_ls_sel),
    .st_type(s_req_ls_type),
    .st_ofs(s_req_ls_addr[1:0]),
    .din(s_req_ls_din),
    .wdata(wdata),
    .wmask(wmask),
    .ld_type(type_q),
    .ld_ofs(m_lsu_wbk_ls_addr[1:0]),
    .rdata(m_dbus_rsp_rdata),
    .ld_data(ld_data)
  );
`ifdef PANDA_RISC_V_LSU_TIMEOUT_EN
  localparam int CW = $clog2(dbus_timeout_th) + 1;
  logic [CW-1:0] cnt;
  // A completing handshake in the last allowed cycle beats the timeout
  assign timeout = (state == CMD || state == RSP) && cnt == CW'(dbus_timeout_th - 1) && !cmd_hs && !rsp_hs;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      stale <= 1'b0;
    end else begin
      cnt <= accept ? '0 : (state == CMD || state == RSP) ? cnt + 1'b1 : cnt;
      stale <= (state == RSP && timeout) ? 1'b1 : m_dbus_rsp_valid ? 1'b0 : stale;
    end
  end
`else
  assign timeout = 1'b0;
  assign stale = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = accept ? (unaligned ? WBK : CMD) : IDLE;
      CMD: state_nxt = cmd_hs ? RSP : timeout ? WBK : CMD;
      RSP: state_nxt = (rsp_hs || timeout) ? WBK : RSP;
      default: state_nxt = m_lsu_wbk_ready ? IDLE : WBK;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      type_q <= '0;
      m_dbus_cmd_addr <= '0;
      m_dbus_cmd_read <= 1'b0;
      m_dbus_cmd_wdata <= '0;
      m_dbus_cmd_wmask <= '0;
      m_lsu_wbk_ls_sel <= 1'b0;
      m_lsu_wbk_rd_id_for_ld <= '0;
      m_lsu_wbk_ls_addr <= '0;
      m_lsu_wbk_dout <= '0;
      m_lsu_wbk_err <= DBUS_ACCESS_NORMAL;
    end else begin
      state <= state_nxt;
      if (accept) begin
        type_q <= s_req_ls_type;
        m_dbus_cmd_addr <= {s_req_ls_addr[31:2], 2'b00};
        m_dbus_cmd_read <= !s_req_ls_sel;
        m_dbus_cmd_wdata <= wdata;
        m_dbus_cmd_wmask <= wmask;
        m_lsu_wbk_ls_sel <= s_req_ls_sel;
        m_lsu_wbk_rd_id_for_ld <= s_req_rd_id;
        m_lsu_wbk_ls_addr <= s_req_ls_addr;
        m_lsu_wbk_dout <= '0;
        m_lsu_wbk_err <= unaligned ? DBUS_ACCESS_LS_UNALIGNED : DBUS_ACCESS_NORMAL;
      end
      if (rsp_hs) begin
        m_lsu_wbk_err <= m_dbus_rsp_err ? DBUS_ACCESS_BUS_ERR : DBUS_ACCESS_NORMAL;
        m_lsu_wbk_dout <= (m_lsu_wbk_ls_sel || m_dbus_rsp_err) ? '0 : ld_data;
      end
      if (timeout) m_lsu_wbk_err <= DBUS_ACCESS_TIMEOUT;
    end
  end
endmodule

// File: doc/panda_risc_v_lsu_core.md
Name: panda_risc_v_lsu_core

Overview:
- Single-outstanding load/store unit; sits between the execute stage and the data bus.
- Checks alignment, builds a byte-lane data-bus command, waits for the response under a timeout, formats load data.
- Presents one writeback/response beat per request to the writeback arbiter (ls_sel, rd_id, dout, ls_addr, err).

Parameters:
- simulation_delay, 1, real; delay on registered assignments (simulation only).
- dbus_timeout_th, 32, cycles allowed from request accept to bus response; must be >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- s_req_ls_sel  in  1  0 = load, 1 = store
- s_req_ls_type  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu; other codes treated as word
- s_req_rd_id  in  5  load target register
- s_req_ls_addr  in  32  byte address
- s_req_ls_din  in  32  store data (low-aligned)
- s_req_valid  in  1 / s_req_ready  out  1
- m_dbus_cmd_addr  out  32  word-aligned address (addr[1:0] = 0)
- m_dbus_cmd_read  out  1
- m_dbus_cmd_wdata  out  32  lane-replicated
- m_dbus_cmd_wmask  out  4
- m_dbus_cmd_valid  out  1 / m_dbus_cmd_ready  in  1
- m_dbus_rsp_rdata  in  32 / m_dbus_rsp_err  in  1
- m_dbus_rsp_valid  in  1 / m_dbus_rsp_ready  out  1
- m_lsu_wbk_ls_sel  out  1 / m_lsu_wbk_rd_id_for_ld  out  5
- m_lsu_wbk_dout  out  32 / m_lsu_wbk_ls_addr  out  32
- m_lsu_wbk_err  out  2  00 normal, 01 unaligned, 10 bus error, 11 timeout
- m_lsu_wbk_valid  out  1 / m_lsu_wbk_ready  in  1

Behaviour:
- Reset: FSM = IDLE; stale = 0; timeout counter = 0; all valids 0; all registered data outputs 0.
- FSM states: IDLE, CMD, RSP, WBK.
- s_req_ready = (state == IDLE) & ~stale.
- IDLE, on accept: latch the request.
  - Unaligned access (h with addr[0] = 1, or w with addr[1:0] != 0) -> WBK, err 01, no bus access. wbk_valid rises in the cycle after accept.
  - Otherwise -> CMD. cmd_valid rises in the cycle after accept.
- CMD: cmd_valid = 1, fields held stable. On cmd_ready -> RSP.
- RSP: rsp_ready = 1. On rsp_valid -> WBK with err = rsp_err ? 10 : 00. wbk_valid rises in the cycle after the response.
- WBK: wbk_valid = 1, fields held until ready. On wbk_ready -> IDLE; the next request may be accepted in the following cycle.
- Store lanes:
  - sb: wmask 0001 << addr[1:0], wdata = {4{din[7:0]}}.
  - sh: wmask 0011 << addr[1:0], wdata = {2{din[15:0]}}.
  - sw: wmask 1111, wdata = din.
  - Loads: wmask 0000.
- Load format: shift rdata right by 8*addr[1:0], then sign- or zero-extend by type.
- wbk_dout = formatted data only for a normal load; 0 otherwise.
- wbk_ls_addr = original byte address. wbk_ls_sel and wbk_rd_id = latched request fields.
- Timeout (optional feature):
  - Counter clears on accept; increments each cycle in CMD/RSP.
  - When counter == dbus_timeout_th-1 and no completing handshake that cycle -> WBK with err 11.
  - A handshake (cmd_ready in CMD, rsp_valid in RSP) in the same cycle wins over timeout.
  - Timeout in CMD: cmd_valid drops (abort permitted by the bus contract); stale stays 0.
  - Timeout in RSP: stale set. While stale, rsp_ready = 1 in every state and the next response is discarded, which clears stale.
  - A late response arriving during WBK does not alter wbk fields.
- rst mid-operation: return to IDLE and drop all valids next edge. stale clears, so the bus must be reset alongside.

Optional Feature:
- Macro: PANDA_RISC_V_LSU_TIMEOUT_EN.
- Defined: timeout counter and stale-drain logic as above.
- Undefined:
  - No counter and no stale logic; CMD/RSP wait indefinitely.
  - err 11 is never produced; s_req_ready = (state == IDLE).

Decomposition:
- Shared package / include:
  - err code constants (DBUS_ACCESS_NORMAL/LS_UNALIGNED/BUS_ERR/TIMEOUT)
  - ls_type funct3 constants
  - FSM state encodings
- One combinational sub-module, panda_risc_v_lsu_data_fmt: store lane/mask generation plus load extraction/extension. The core keeps the FSM, counter and handshakes.

Test Plan:
- lh addr 0x1002, rdata 0x8001_xxxx, rsp_err 0 -> wbk: dout 0xFFFF8001, err 00, rd_id echoed, ls_addr 0x1002.
- sb addr 0x2003, din 0x000000A5 -> cmd: wmask 1000, wdata 0xA5A5A5A5, addr 0x2000; wbk: ls_sel 1, err 00, dout 0.
- lw addr 0x3001 -> no cmd_valid ever; wbk_valid the cycle after accept, err 01.
- lbu with rsp_err 1 -> wbk err 10, dout 0; then hold wbk_ready 0 for 5 cycles -> all fields stable.
- With macro defined and dbus_timeout_th 8: cmd accepted, no response for 8 cycles -> err 11. Inject a late response -> consumed with rsp_ready 1 and not reported; s_req_ready stays 0 until it arrives.
- rsp_valid in exactly the timeout cycle -> err 00 result, stale stays 0. rst asserted in RSP -> all valids 0 next cycle, s_req_ready 1.
